// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    // XZR reads as zero and is never written, so it can never carry a dependency.
    localparam logic [4:0] XZR           = 5'd31;
    localparam int         DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // count up on i_inc, hold at all-ones, clear to zero on i_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use and CBZ operand stalls, taken-branch
// IF/ID flush, halt/drain FSM and saturating stall/flush counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic [4:0]       targetReg_EX,
    input  logic             MemRead_MEM,
    input  logic [4:0]       targetReg_MEM,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             useRn_ID,
    input  logic             useRm_ID,
    input  logic             cbz_ID,
    input  logic             brTaken_ID,
    input  logic             halt_req,
    input  logic             perf_clr,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int            DW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYC - 1);

    hz_state_t     r_state, w_state_nxt;
    logic [DW-1:0] r_dcnt, w_dcnt_nxt;
    logic          r_halted;
    logic          w_lu, w_cz1, w_cz2, w_hz;
    logic          w_run, w_inc_stall, w_inc_flush;

    // Hazard detection; a compare against XZR never matches.
    assign w_lu  = MemRead_EX && (targetReg_EX != XZR) &&
                   ((useRn_ID && (Rn_ID == targetReg_EX)) ||
                    (useRm_ID && (Rm_ID == targetReg_EX)));
    // CBZ resolves in ID so it must wait for any producer in EX, and for a
    // load still in MEM (its data only exists after the MEM stage).
    assign w_cz1 = cbz_ID && RegWrite_EX && (targetReg_EX != XZR) &&
                   (Rm_ID == targetReg_EX);
    assign w_cz2 = cbz_ID && MemRead_MEM && (targetReg_MEM != XZR) &&
                   (Rm_ID == targetReg_MEM);
    assign w_hz  = w_lu || w_cz1 || w_cz2;

    assign w_run       = (r_state == RUN);
    assign w_inc_stall = w_run && w_hz;
    assign w_inc_flush = w_run && !w_hz && brTaken_ID;

    // state and drain counter registers; halted mirrors entry into HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_dcnt   <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_halted <= (w_state_nxt == HALTED);
        end
    end

    // next-state: halt is deferred while a hazard is pending; dropping
    // halt_req aborts a drain and restarts the drain count next time
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            RUN: begin
                w_dcnt_nxt = '0;
                if (halt_req && !w_hz)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!halt_req) begin
                    w_state_nxt = RUN;
                    w_dcnt_nxt  = '0;
                end else if (r_dcnt == DLAST) begin
                    w_state_nxt = HALTED;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + DW'(1);
                end
            end
            HALTED: begin
                if (!halt_req)
                    w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
                w_dcnt_nxt  = '0;
            end
        endcase
    end

    // pipeline controls: freeze+bubble unless running hazard-free; during
    // reset also flush IF/ID so no stale instruction survives
    always_comb begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_bubble = 1'b1;
        IFID_flush  = 1'b0;
        if (!rst_n) begin
            IFID_flush = 1'b1;
        end else if (w_run && !w_hz) begin
            PCWrite     = 1'b1;
            IFIDWrite   = 1'b1;
            IDEX_bubble = 1'b0;
            IFID_flush  = brTaken_ID;
        end
    end

    assign halted = r_halted;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_inc_stall),
        .i_clr (perf_clr),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_inc_flush),
        .i_clr (perf_clr),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead_EX, RegWrite_EX, MemRead_MEM;
    logic [4:0]  targetReg_EX, targetReg_MEM, Rn_ID, Rm_ID;
    logic        useRn_ID, useRm_ID, cbz_ID, brTaken_ID, halt_req, perf_clr;
    logic        PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic        fl;
        logic        hlt;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    bit    done   = 1'b0;

    hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemRead_EX    (MemRead_EX),
        .RegWrite_EX   (RegWrite_EX),
        .targetReg_EX  (targetReg_EX),
        .MemRead_MEM   (MemRead_MEM),
        .targetReg_MEM (targetReg_MEM),
        .Rn_ID         (Rn_ID),
        .Rm_ID         (Rm_ID),
        .useRn_ID      (useRn_ID),
        .useRm_ID      (useRm_ID),
        .cbz_ID        (cbz_ID),
        .brTaken_ID    (brTaken_ID),
        .halt_req      (halt_req),
        .perf_clr      (perf_clr),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEX_bubble   (IDEX_bubble),
        .IFID_flush    (IFID_flush),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    // monitor: compare every pending expectation at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, halted, stall_cnt, flush_cnt};
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL %s: got pcw=%b ifw=%b bub=%b fl=%b hlt=%b sc=%h fc=%h, want pcw=%b ifw=%b bub=%b fl=%b hlt=%b sc=%h fc=%h",
                         nm, a.pcw, a.ifw, a.bub, a.fl, a.hlt, a.sc, a.fc,
                         e.pcw, e.ifw, e.bub, e.fl, e.hlt, e.sc, e.fc);
            end
        end
    end

    initial begin
        #2_000_000;
        if (!done) begin
            n_miss++;
            $display("FAIL timeout: stimulus did not complete, %0d vectors, %0d miscompares", n_vec, n_miss);
            $finish;
        end
    end

    task automatic chk(input string nm, input logic pcw, input logic ifw,
                       input logic bub, input logic fl, input logic hlt,
                       input logic [15:0] sc, input logic [15:0] fc);
        exp_q.push_back({pcw, ifw, bub, fl, hlt, sc, fc});
        name_q.push_back(nm);
    endtask

    task automatic chk_rst_now(input string nm);
        n_vec++;
        if (PCWrite !== 1'b0 || IFIDWrite !== 1'b0 || IDEX_bubble !== 1'b1 ||
            IFID_flush !== 1'b1 || halted !== 1'b0 ||
            stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_miss++;
            $display("FAIL %s: reset state pcw=%b ifw=%b bub=%b fl=%b hlt=%b sc=%h fc=%h",
                     nm, PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, halted, stall_cnt, flush_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        MemRead_EX = 0; RegWrite_EX = 0; targetReg_EX = 0;
        MemRead_MEM = 0; targetReg_MEM = 0; Rn_ID = 0; Rm_ID = 0;
        useRn_ID = 0; useRm_ID = 0; cbz_ID = 0; brTaken_ID = 0;
        perf_clr = 0;
    endtask

    task automatic lu_on(input logic [4:0] r);
        MemRead_EX = 1; targetReg_EX = r; Rn_ID = r; useRn_ID = 1;
    endtask

    initial begin
        rst_n = 0; halt_req = 0;
        clr_in();
        #1;
        chk_rst_now("reset_direct");
        chk("reset", 0, 0, 1, 1, 0, 16'd0, 16'd0);
        @(negedge clk); #1;
        rst_n = 1;
        tick();

        // load-use
        lu_on(5);                                        chk("lu_rn", 0,0,1,0,0, 0,0); tick();
        clr_in(); lu_on(31);                             chk("lu_xzr", 1,1,0,0,0, 1,0); tick();
        clr_in(); MemRead_EX = 1; targetReg_EX = 7; Rm_ID = 7; useRm_ID = 1;
                                                         chk("lu_rm", 0,0,1,0,0, 1,0); tick();
        useRm_ID = 0; Rn_ID = 7;                         chk("lu_nouse", 1,1,0,0,0, 2,0); tick();
        clr_in(); RegWrite_EX = 1; targetReg_EX = 5; Rn_ID = 5; useRn_ID = 1;
                                                         chk("alu_fwd", 1,1,0,0,0, 2,0); tick();

        // CBZ fed by a load: two stall cycles
        clr_in(); MemRead_EX = 1; RegWrite_EX = 1; targetReg_EX = 9; cbz_ID = 1; Rm_ID = 9;
                                                         chk("cz1", 0,0,1,0,0, 2,0); tick();
        clr_in(); MemRead_MEM = 1; targetReg_MEM = 9; cbz_ID = 1; Rm_ID = 9;
                                                         chk("cz2", 0,0,1,0,0, 3,0); tick();
        clr_in(); cbz_ID = 1; Rm_ID = 9;                 chk("cz_go", 1,1,0,0,0, 4,0); tick();
        RegWrite_EX = 1; targetReg_EX = 31; MemRead_MEM = 1; targetReg_MEM = 31; Rm_ID = 31;
                                                         chk("cz_xzr", 1,1,0,0,0, 4,0); tick();
        clr_in(); RegWrite_EX = 1; targetReg_EX = 3; Rm_ID = 3;
                                                         chk("cz_nocbz", 1,1,0,0,0, 4,0); tick();

        // taken branch flush vs stall
        clr_in(); brTaken_ID = 1;                        chk("br_flush", 1,1,0,1,0, 4,0); tick();
        lu_on(4);                                        chk("br_stall", 0,0,1,0,0, 4,1); tick();
        clr_in();                                        chk("br_after", 1,1,0,0,0, 5,1); tick();

        // halt and drain, entry cycle still flushes
        halt_req = 1; brTaken_ID = 1;                    chk("halt_entry", 1,1,0,1,0, 5,1); tick();
                                                         chk("drain0", 0,0,1,0,0, 5,2); tick();
        clr_in(); lu_on(6);                              chk("drain1", 0,0,1,0,0, 5,2); tick();
        clr_in();                                        chk("drain2", 0,0,1,0,0, 5,2); tick();
                                                         chk("halted", 0,0,1,0,1, 5,2); tick();
        halt_req = 0;                                    chk("halted_rel", 0,0,1,0,1, 5,2); tick();
                                                         chk("run_again", 1,1,0,0,0, 5,2); tick();

        // deferral behind a hazard, abort, then a full re-drain
        halt_req = 1; lu_on(8);                          chk("defer0", 0,0,1,0,0, 5,2); tick();
                                                         chk("defer1", 0,0,1,0,0, 6,2); tick();
        clr_in();                                        chk("defer_entry", 1,1,0,0,0, 7,2); tick();
                                                         chk("abort_d0", 0,0,1,0,0, 7,2); tick();
        halt_req = 0;                                    chk("abort_d1", 0,0,1,0,0, 7,2); tick();
                                                         chk("abort_run", 1,1,0,0,0, 7,2); tick();
        halt_req = 1;                                    chk("re_entry", 1,1,0,0,0, 7,2); tick();
                                                         chk("re_d0", 0,0,1,0,0, 7,2); tick();
                                                         chk("re_d1", 0,0,1,0,0, 7,2); tick();
                                                         chk("re_d2", 0,0,1,0,0, 7,2); tick();
        halt_req = 0;                                    chk("re_halted", 0,0,1,0,1, 7,2); tick();
                                                         chk("re_run", 1,1,0,0,0, 7,2); tick();

        // counters: clear beats increment, then saturate
        perf_clr = 1; lu_on(2);                          chk("clr_inc", 0,0,1,0,0, 7,2); tick();
        perf_clr = 0;                                    chk("clr_done", 0,0,1,0,0, 0,0); tick();
        for (int i = 0; i < 65534; i++) tick();
                                                         chk("sat_reach", 0,0,1,0,0, 16'hFFFF,0); tick();
                                                         chk("sat_hold", 0,0,1,0,0, 16'hFFFF,0); tick();
        clr_in(); perf_clr = 1;                          chk("sat_clr", 1,1,0,0,0, 16'hFFFF,0); tick();
        perf_clr = 0;                                    chk("sat_zero", 1,1,0,0,0, 0,0); tick();

        // asynchronous reset in the middle of a drain
        brTaken_ID = 1;                                  chk("pre_rst_br", 1,1,0,1,0, 0,0); tick();
        brTaken_ID = 0; halt_req = 1;                    chk("pre_rst_entry", 1,1,0,0,0, 0,1); tick();
                                                         chk("pre_rst_d0", 0,0,1,0,0, 0,1);
        @(negedge clk); #1;
        rst_n = 0;
        #1;
        chk_rst_now("rst_mid_drain_direct");
        chk("rst_mid_drain", 0,0,1,1,0, 0,0);
        @(negedge clk); #1;
        rst_n = 1; halt_req = 0;
        tick();
                                                         chk("post_rst", 1,1,0,0,0, 0,0);
        @(negedge clk); #1;

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        if (n_miss == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Stall/flush controller for the 5-stage ARM pipeline. It handles the hazards that data forwarding cannot resolve:
- load-use stalls
- CBZ/CBNZ operand stalls (branch resolved in ID)
- taken-branch IF/ID flush
- a halt/drain FSM that freezes fetch and empties EX/MEM/WB

It drives PC/IF-ID write enables and the ID/EX bubble mux, and exposes saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt
DRAIN_CYC, 3, bubble cycles injected before halted asserts (covers EX, MEM, WB)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
MemRead_EX  in  1  instruction in EX is a load
RegWrite_EX  in  1  instruction in EX writes a register
targetReg_EX  in  5  Rd of instruction in EX
MemRead_MEM  in  1  instruction in MEM is a load
targetReg_MEM  in  5  Rd of instruction in MEM
Rn_ID  in  5  Rn of instruction in ID
Rm_ID  in  5  Rm (or Rt for CBZ/STUR) of instruction in ID
useRn_ID  in  1  ID instruction reads Rn
useRm_ID  in  1  ID instruction reads Rm/Rt
cbz_ID  in  1  ID instruction is CBZ/CBNZ (tests Rm_ID)
brTaken_ID  in  1  branch in ID resolved taken
halt_req  in  1  level request to drain and freeze
perf_clr  in  1  synchronous clear of both counters
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register enable
IDEX_bubble  out  1  zero control bits into ID/EX
IFID_flush  out  1  zero IF/ID instruction
halted  out  1  pipeline drained and frozen (registered)
stall_cnt  out  CNT_W  hazard stall cycles, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Register X31 (XZR) never produces a hazard on any compare.
- lu: MemRead_EX & targetReg_EX!=31 & ((useRn_ID & Rn_ID==targetReg_EX) | (useRm_ID & Rm_ID==targetReg_EX)).
- cz1: cbz_ID & RegWrite_EX & targetReg_EX!=31 & Rm_ID==targetReg_EX.
- cz2: cbz_ID & MemRead_MEM & targetReg_MEM!=31 & Rm_ID==targetReg_MEM.
- hz = lu | cz1 | cz2, combinational, same cycle.
  - A load feeding CBZ therefore stalls 2 cycles: cz1, then cz2.
- FSM states: RUN, DRAIN, HALTED. Reset state RUN.
- RUN, hz=1: PCWrite=0, IFIDWrite=0, IDEX_bubble=1, IFID_flush=0. brTaken_ID is ignored (operands not valid).
- RUN, hz=0: PCWrite=1, IFIDWrite=1, IDEX_bubble=0, IFID_flush=brTaken_ID.
- RUN→DRAIN on halt_req=1 and hz=0. If hz=1, the halt is deferred until hz clears.
  - In the entry cycle, RUN outputs apply, including any flush.
- DRAIN: PCWrite=0, IFIDWrite=0, IDEX_bubble=1, IFID_flush=0. The ID instruction is held, not lost.
  - drain_cnt counts 0..DRAIN_CYC-1.
  - DRAIN→HALTED after DRAIN_CYC cycles in DRAIN.
  - DRAIN→RUN immediately if halt_req=0; drain_cnt is cleared.
- HALTED: same outputs as DRAIN, halted=1 registered.
  - HALTED→RUN on halt_req=0, with halted=0 in the first RUN cycle.
- Reset asserted, any state: PCWrite=0, IFIDWrite=0, IDEX_bubble=1, IFID_flush=1.
  - halted=0, drain_cnt=0, stall_cnt=0, flush_cnt=0, state=RUN.
  - Reset mid-DRAIN abandons the drain.
- stall_cnt increments on each cycle with state=RUN & hz=1.
- flush_cnt increments on each cycle with state=RUN & hz=0 & brTaken_ID=1.
- Both counters saturate at all-ones.
- perf_clr has priority over increment: the counter reads 0 the next cycle.
- Latency:
  - enables and bubble/flush: combinational, same cycle
  - halted: 1 cycle after the DRAIN_CYC-th drain cycle
  - counters: 1 cycle

Decomposition:
- pipe_pkg: hz_state_t enum {RUN, DRAIN, HALTED}; localparam XZR = 5'd31; default DRAIN_CYC.
- One sub-module, sat_counter, parameterised by width, with inputs inc and clr. Instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use stall: MemRead_EX=1, targetReg_EX=5, Rn_ID=5, useRn_ID=1 → PCWrite=0, IFIDWrite=0, IDEX_bubble=1; stall_cnt 0→1. Repeat with targetReg_EX=31 → no stall.
- CBZ on load: cycle 1 MemRead_EX=1, RegWrite_EX=1, targetReg_EX=9, cbz_ID=1, Rm_ID=9 → stall. Cycle 2 MemRead_MEM=1, targetReg_MEM=9, EX bubble → stall. Cycle 3 → PCWrite=1; stall_cnt=2.
- Branch flush vs stall: brTaken_ID=1, hz=0 → IFID_flush=1, flush_cnt+1. brTaken_ID=1 with lu=1 → IFID_flush=0, flush_cnt unchanged.
- Halt drain: halt_req=1 in RUN, hz=0 → 3 DRAIN cycles with IDEX_bubble=1, halted=1 on the 4th edge. halt_req=0 → RUN next cycle, halted=0.
- Halt abort and deferral: halt_req=1 with lu=1 → stays RUN until lu=0. Drop halt_req after 1 DRAIN cycle → RUN, halted never asserts.
- Counters and reset: force stall_cnt to 16'hFFFF via 65535 stall cycles, then more stalls → holds at FFFF. perf_clr=1 → 0. rst_n=0 mid-DRAIN → all outputs at reset values immediately (asynchronous).
